// File: rtl/minibyte_ctrl.sv
// minibyte_ctrl: multi-cycle control unit for the minibyte CPU.
// Decodes opcodes, sequences the A/M/PC datapath and keeps Z/N.
module minibyte_ctrl (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic [7:0] data_in,
   input  logic       flag_z_in,
   input  logic       flag_n_in,
   output logic       set_a_out,
   output logic       set_m_out,
   output logic       set_pc_out,
   output logic       inc_pc_out,
   output logic       addr_mux_out,
   output logic [2:0] alu_op_out,
   output logic       we_out,
   output logic       halted_out
);

   typedef enum logic [1:0] {
      S_FETCH,
      S_OPER,
      S_EXEC,
      S_HALT
   } state_t;

   localparam logic [2:0] ALU_PASS_B = 3'd0;
   localparam logic [2:0] ALU_ADD    = 3'd1;
   localparam logic [2:0] ALU_SUB    = 3'd2;
   localparam logic [2:0] ALU_AND    = 3'd3;
   localparam logic [2:0] ALU_OR     = 3'd4;
   localparam logic [2:0] ALU_XOR    = 3'd5;
   localparam logic [2:0] ALU_PASS_A = 3'd6;

   state_t     r_state;
   state_t     w_next;
   logic [7:0] r_ir;
   logic       r_z;
   logic       r_n;

   logic [3:0] w_op;
   logic       w_direct;
   logic       w_is_ld_alu;
   logic       w_is_sta;
   logic       w_is_jmp;
   logic       w_is_bz;
   logic       w_is_bn;
   logic       w_taken;
   logic [2:0] w_alu_sel;

   logic [3:0] w_f_op;
   logic       w_f_halt;
   logic       w_f_single;

   logic       w_set_a;
   logic       w_set_m;
   logic       w_set_pc;
   logic       w_inc_pc;
   logic       w_addr_mux;
   logic [2:0] w_alu_op;
   logic       w_we;
   logic       w_halted;
   logic       w_unused;

   assign w_op     = r_ir[7:4];
   assign w_direct = r_ir[3];
   assign w_unused = ^r_ir[2:0];

   always_comb begin
      w_is_ld_alu = 1'b0;
      w_is_sta    = 1'b0;
      w_is_jmp    = 1'b0;
      w_is_bz     = 1'b0;
      w_is_bn     = 1'b0;
      w_alu_sel   = ALU_PASS_B;
      unique case (1'b1)
         (w_op == 4'h1): w_is_ld_alu = 1'b1;
         (w_op == 4'h2): w_is_sta    = 1'b1;
         (w_op == 4'h3): begin
            w_is_ld_alu = 1'b1;
            w_alu_sel   = ALU_ADD;
         end
         (w_op == 4'h4): begin
            w_is_ld_alu = 1'b1;
            w_alu_sel   = ALU_SUB;
         end
         (w_op == 4'h5): begin
            w_is_ld_alu = 1'b1;
            w_alu_sel   = ALU_AND;
         end
         (w_op == 4'h6): begin
            w_is_ld_alu = 1'b1;
            w_alu_sel   = ALU_OR;
         end
         (w_op == 4'h7): begin
            w_is_ld_alu = 1'b1;
            w_alu_sel   = ALU_XOR;
         end
         (w_op == 4'h8): w_is_jmp = 1'b1;
         (w_op == 4'h9): w_is_bz  = 1'b1;
         (w_op == 4'hA): w_is_bn  = 1'b1;
         default: ;
      endcase
   end

   assign w_taken = (w_is_bz & r_z) | (w_is_bn & r_n);

   // Opcode byte is still on data_in during FETCH, IR not yet loaded
   assign w_f_op     = data_in[7:4];
   assign w_f_halt   = (w_f_op == 4'hF);
   assign w_f_single = (w_f_op == 4'h0) |
                       ((w_f_op >= 4'hB) & (w_f_op <= 4'hE));

   always_comb begin
      w_next     = r_state;
      w_set_a    = 1'b0;
      w_set_m    = 1'b0;
      w_set_pc   = 1'b0;
      w_inc_pc   = 1'b0;
      w_addr_mux = 1'b0;
      w_alu_op   = ALU_PASS_B;
      w_we       = 1'b0;
      w_halted   = 1'b0;
      unique case (r_state)
         S_FETCH: begin
            w_inc_pc = 1'b1;
            if (w_f_halt)
               w_next = S_HALT;
            else if (w_f_single)
               w_next = S_FETCH;
            else
               w_next = S_OPER;
         end
         S_OPER: begin
            w_next = S_FETCH;
            if (w_is_ld_alu && !w_direct) begin
               w_alu_op = w_alu_sel;
               w_set_a  = 1'b1;
               w_inc_pc = 1'b1;
            end else if (w_is_ld_alu || w_is_sta) begin
               w_set_m  = 1'b1;
               w_inc_pc = 1'b1;
               w_next   = S_EXEC;
            end else if (w_is_jmp || w_taken) begin
               w_set_pc = 1'b1;
            end else begin
               w_inc_pc = 1'b1;
            end
         end
         S_EXEC: begin
            w_addr_mux = 1'b1;
            w_next     = S_FETCH;
            if (w_is_ld_alu) begin
               w_alu_op = w_alu_sel;
               w_set_a  = 1'b1;
            end else if (w_is_sta) begin
               w_alu_op = ALU_PASS_A;
               w_we     = 1'b1;
            end
         end
         S_HALT: begin
            w_halted = 1'b1;
         end
      endcase
   end

   // Reset masks every strobe so an aborted STA never writes
   assign set_a_out    = w_set_a    & ~rst_in;
   assign set_m_out    = w_set_m    & ~rst_in;
   assign set_pc_out   = w_set_pc   & ~rst_in;
   assign inc_pc_out   = w_inc_pc   & ~rst_in;
   assign addr_mux_out = w_addr_mux & ~rst_in;
   assign alu_op_out   = rst_in ? 3'd0 : w_alu_op;
   assign we_out       = w_we       & ~rst_in;
   assign halted_out   = w_halted   & ~rst_in;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state <= S_FETCH;
         r_ir    <= 8'h00;
         r_z     <= 1'b0;
         r_n     <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_FETCH)
            r_ir <= data_in;
         if (w_set_a) begin
            r_z <= flag_z_in;
            r_n <= flag_n_in;
         end
      end
   end

endmodule

// File: tb/tb_minibyte_ctrl.sv
// tb_minibyte_ctrl: minibyte controller driving a behavioural datapath,
// checked against directed programs and an instruction-level model.
module tb_minibyte_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] din;
   logic       fz, fn;
   logic       set_a, set_m, set_pc, inc_pc, mux, we, halted;
   logic [2:0] aop;

   always #5 clk = ~clk;

   minibyte_ctrl dut (
      .clk_in(clk),
      .rst_in(rst),
      .data_in(din),
      .flag_z_in(fz),
      .flag_n_in(fn),
      .set_a_out(set_a),
      .set_m_out(set_m),
      .set_pc_out(set_pc),
      .inc_pc_out(inc_pc),
      .addr_mux_out(mux),
      .alu_op_out(aop),
      .we_out(we),
      .halted_out(halted)
   );

   // behavioural datapath
   logic [7:0] img [256];
   logic [7:0] mem [256];
   logic [7:0] dp_a, dp_m, dp_pc, addr, alu;
   logic [9:0] ctl;

   assign addr = mux ? dp_m : dp_pc;
   assign din  = mem[addr];
   assign fz   = (alu == 8'h00);
   assign fn   = alu[7];
   assign ctl  = {set_a, set_m, set_pc, inc_pc, mux, aop, we, halted};

   always_comb begin
      alu = 8'h00;
      case (aop)
         3'd0: alu = din;
         3'd1: alu = dp_a + din;
         3'd2: alu = dp_a - din;
         3'd3: alu = dp_a & din;
         3'd4: alu = dp_a | din;
         3'd5: alu = dp_a ^ din;
         3'd6: alu = dp_a;
         default: alu = 8'h00;
      endcase
   end

   always @(posedge clk) begin
      if (rst) begin
         dp_a  <= 8'h00;
         dp_m  <= 8'h00;
         dp_pc <= 8'h00;
         for (int i = 0; i < 256; i++) mem[i] <= img[i];
      end else begin
         if (set_a) dp_a <= alu;
         if (set_m) dp_m <= alu;
         if (set_pc) dp_pc <= alu;
         else if (inc_pc) dp_pc <= dp_pc + 8'd1;
         if (we) mem[addr] <= alu;
      end
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic inv();
      chk("pc_set_inc", {31'd0, set_pc & inc_pc}, 32'd0);
      chk("set_onehot", {31'd0, $onehot0({set_a, set_m, set_pc})}, 32'd1);
      chk("aop_not7", {31'd0, aop == 3'd7}, 32'd0);
   endtask

   task automatic clear_img();
      for (int i = 0; i < 256; i++) img[i] = 8'h00;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      chk("rst_outs", {22'd0, ctl}, 32'd0);
      rst = 1'b0;
      #1;
   endtask

   logic [7:0] t_addr [64];
   logic [7:0] t_dat  [64];
   logic [9:0] t_ctl  [64];
   logic       t_we   [64];
   logic       t_halt [64];

   task automatic run_trace(input int n);
      for (int i = 0; i < n; i++) begin
         t_addr[i] = addr;
         t_dat[i]  = alu;
         t_ctl[i]  = ctl;
         t_we[i]   = we;
         t_halt[i] = halted;
         inv();
         tick();
      end
   endtask

   function automatic int first_halt(input int n);
      for (int i = 0; i < n; i++)
         if (t_halt[i]) return i;
      return -1;
   endfunction

   // instruction-level reference model
   logic [7:0] m_mem [256];
   logic [7:0] m_a, m_pc;
   logic       m_z, m_n;

   task automatic model_step(output int cyc, output bit hlt);
      logic [7:0] op, p1, opnd, val;
      int         hi, r;
      bit         taken;
      op   = m_mem[m_pc];
      hi   = int'(op[7:4]);
      p1   = m_pc + 8'd1;
      opnd = m_mem[p1];
      hlt  = 1'b0;
      cyc  = 1;
      if (hi == 0 || (hi >= 11 && hi <= 14)) begin
         m_pc = p1;
      end else if (hi == 15) begin
         m_pc = p1;
         hlt  = 1'b1;
      end else if (hi == 2) begin
         m_mem[opnd] = m_a;
         m_pc = p1 + 8'd1;
         cyc  = 3;
      end else if (hi >= 8) begin
         taken = (hi == 8) || (hi == 9 && m_z) || (hi == 10 && m_n);
         m_pc  = taken ? opnd : p1 + 8'd1;
         cyc   = 2;
      end else begin
         val = op[3] ? m_mem[opnd] : opnd;
         cyc = op[3] ? 3 : 2;
         case (hi)
            1: r = int'(val);
            3: r = int'(m_a) + int'(val);
            4: r = int'(m_a) - int'(val);
            5: r = int'(m_a & val);
            6: r = int'(m_a | val);
            default: r = int'(m_a ^ val);
         endcase
         r    = (r + 256) % 256;
         m_a  = r[7:0];
         m_z  = (r == 0);
         m_n  = (r >= 128);
         m_pc = p1 + 8'd1;
      end
   endtask

   initial begin
      int nwe, widx, hidx, ndiff, cyc;
      bit hlt;

      // store-and-halt program
      clear_img();
      {img[0], img[1], img[2], img[3]} = {8'h11, 8'h05, 8'h31, 8'h03};
      {img[4], img[5], img[6]} = {8'h28, 8'h80, 8'hF0};
      do_reset();
      run_trace(30);
      nwe  = 0;
      widx = -1;
      for (int i = 0; i < 30; i++)
         if (t_we[i]) begin
            nwe++;
            widx = i;
         end
      chk("t1_we_count", nwe, 1);
      chk("t1_we_cycle", widx, 6);
      chk("t1_we_addr", {24'd0, t_addr[6]}, 32'h80);
      chk("t1_we_data", {24'd0, t_dat[6]}, 32'h08);
      chk("t1_mem80", {24'd0, mem[8'h80]}, 32'h08);
      chk("t1_halt_cycle", first_halt(30), 8);
      chk("t1_halt_ctl", {22'd0, t_ctl[8]}, 32'd1);
      ndiff = 0;
      for (int i = 8; i < 30; i++)
         if (t_ctl[i] !== t_ctl[8]) ndiff++;
      chk("t1_halt_const", ndiff, 0);

      // SUB to zero then BZ taken
      clear_img();
      {img[0], img[1], img[2], img[3]} = {8'h11, 8'h05, 8'h41, 8'h05};
      {img[4], img[5]} = {8'h91, 8'h20};
      img[8'h20] = 8'hF0;
      do_reset();
      run_trace(10);
      chk("t2_bz_fetch", {24'd0, t_addr[6]}, 32'h20);
      chk("t2_halt", first_halt(10), 7);

      // BN untaken with N=0
      clear_img();
      {img[0], img[1], img[2], img[3]} = {8'h11, 8'h05, 8'hA1, 8'h20};
      img[4] = 8'hF0;
      img[8'h20] = 8'hF0;
      do_reset();
      run_trace(10);
      chk("t2_bn_fetch", {24'd0, t_addr[4]}, 32'h04);
      chk("t2_bn_halt", first_halt(10), 5);

      // direct LDA, then BN taken, BZ untaken
      clear_img();
      {img[0], img[1], img[2], img[3]} = {8'h19, 8'h40, 8'hA0, 8'h10};
      img[8'h40] = 8'h9C;
      {img[8'h10], img[8'h11], img[8'h12]} = {8'h90, 8'h30, 8'hF0};
      img[8'h30] = 8'hF0;
      do_reset();
      run_trace(12);
      chk("t3_addr0", {24'd0, t_addr[0]}, 32'h00);
      chk("t3_addr1", {24'd0, t_addr[1]}, 32'h01);
      chk("t3_addr2", {24'd0, t_addr[2]}, 32'h40);
      chk("t3_addr3", {24'd0, t_addr[3]}, 32'h02);
      chk("t3_exec_ctl", {22'd0, t_ctl[2]}, 32'h220);
      chk("t3_bn_taken", {24'd0, t_addr[5]}, 32'h10);
      chk("t3_bz_untaken", {24'd0, t_addr[7]}, 32'h12);
      chk("t3_halt", first_halt(12), 8);
      chk("t3_a", {24'd0, dp_a}, 32'h9C);

      // undefined opcode, NOPs, HLT
      clear_img();
      img[0] = 8'hB3;
      img[5] = 8'hF0;
      do_reset();
      run_trace(10);
      chk("t4_undef_ctl", {22'd0, t_ctl[0]}, 32'h040);
      chk("t4_next_fetch", {24'd0, t_addr[1]}, 32'h01);
      chk("t4_hlt_addr", {24'd0, t_addr[5]}, 32'h05);
      chk("t4_halt", first_halt(10), 6);
      chk("t4_pc", {24'd0, dp_pc}, 32'h06);

      // reset during STA EXEC
      clear_img();
      {img[0], img[1], img[2], img[3]} = {8'h11, 8'h80, 8'h28, 8'h40};
      img[4] = 8'hF0;
      do_reset();
      repeat (4) begin
         inv();
         tick();
      end
      chk("t5_pre_we", {31'd0, we}, 32'd1);
      clear_img();
      {img[0], img[1], img[2]} = {8'hA1, 8'h10, 8'hF0};
      img[8'h10] = 8'hF0;
      rst = 1'b1;
      #1;
      chk("t5_we_rst", {31'd0, we}, 32'd0);
      chk("t5_ctl_rst", {22'd0, ctl}, 32'd0);
      tick();
      rst = 1'b0;
      #1;
      run_trace(6);
      chk("t5_first_fetch", {24'd0, t_addr[0]}, 32'h00);
      chk("t5_n_cleared", {24'd0, t_addr[2]}, 32'h02);
      chk("t5_halt", first_halt(6), 3);

      // JMP to 0xFF, NOP there wraps PC to 0x00
      clear_img();
      {img[0], img[1]} = {8'h80, 8'hFF};
      do_reset();
      run_trace(6);
      chk("t6_jmp_fetch", {24'd0, t_addr[2]}, 32'hFF);
      chk("t6_wrap", {24'd0, t_addr[3]}, 32'h00);
      chk("t6_wrap_next", {24'd0, t_addr[4]}, 32'h01);

      // random programs vs instruction-level model
      for (int t = 0; t < 20; t++) begin
         for (int i = 0; i < 256; i++) begin
            img[i]   = 8'($urandom);
            m_mem[i] = img[i];
         end
         m_a  = 8'h00;
         m_pc = 8'h00;
         m_z  = 1'b0;
         m_n  = 1'b0;
         do_reset();
         for (int k = 0; k < 40; k++) begin
            model_step(cyc, hlt);
            repeat (cyc) begin
               inv();
               tick();
            end
            chk("rnd_pc", {24'd0, dp_pc}, {24'd0, m_pc});
            chk("rnd_a", {24'd0, dp_a}, {24'd0, m_a});
            chk("rnd_halted", {31'd0, halted}, {31'd0, hlt});
            if (hlt) break;
         end
         ndiff = 0;
         for (int i = 0; i < 256; i++)
            if (mem[i] !== m_mem[i]) ndiff++;
         chk("rnd_mem", ndiff, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/minibyte_ctrl.md
# minibyte_ctrl

Control unit for the minibyte CPU. It fetches and decodes instructions from `data_in`, sequences the datapath (A/M/PC registers, address mux, ALU, write enable) through a small multi-cycle state machine, and holds the latched Z/N flags used for branches. It drives every `ctrl_*` net of `minibyte_cpu`, which are currently tied off.

## Interface
- No parameters.
- `clk_in` in 1: the single clock; all state updates on the rising edge.
- `rst_in` in 1: synchronous, active-high reset.
- `data_in` in 8: memory read data; carries the opcode in FETCH.
- `flag_z_in` in 1: ALU zero flag for the current result.
- `flag_n_in` in 1: ALU negative flag (result bit 7).
- `set_a_out` out 1: load A from the main bus.
- `set_m_out` out 1: load M from the main bus.
- `set_pc_out` out 1: load PC from the main bus.
- `inc_pc_out` out 1: PC <= PC+1, mod 256.
- `addr_mux_out` out 1: 0 selects PC, 1 selects M onto `addr_out`.
- `alu_op_out` out 3: 0 PASS_B, 1 ADD, 2 SUB (A−B), 3 AND, 4 OR, 5 XOR, 6 PASS_A; 7 is never driven. All arithmetic is mod 256.
- `we_out` out 1: memory write strobe.
- `halted_out` out 1: high in HALT.

## Operation
- Opcode byte: bits [7:4] are the operation; bit 3 is the mode (0 = immediate, 1 = direct via M); bits [2:0] are ignored. The operand byte follows the opcode, except for NOP and HLT.
- Operations:
  - 0x0 NOP.
  - 0x1 LDA: A <= operand.
  - 0x2 STA: direct only; mode bit is ignored.
  - 0x3 ADD, 0x4 SUB, 0x5 AND, 0x6 OR, 0x7 XOR: A <= A op operand.
  - 0x8 JMP: PC <= operand byte.
  - 0x9 BZ: branch to operand if Z=1.
  - 0xA BN: branch to operand if N=1.
  - 0xF HLT.
  - 0xB–0xE: undefined; executed as a 1-byte NOP.
- Internal state: `state` (FETCH, OPER, EXEC, HALT), 8-bit IR, and latched flags Z and N.
- Outputs are combinational from `state`, IR, flags and `data_in`. Any output not listed for a state is 0.
- FETCH:
  - `addr_mux`=0, `inc_pc`=1; IR <= `data_in`.
  - Next state: HLT goes to HALT; NOP or undefined goes to FETCH; everything else goes to OPER.
- OPER (`addr_mux`=0; `data_in` is the operand byte):
  - Immediate LDA/ALU: `alu_op` per operation (PASS_B for LDA), `set_a`=1, `inc_pc`=1. Z <= `flag_z_in`, N <= `flag_n_in`. Next state FETCH.
  - Direct LDA/ALU, and STA: `alu_op`=PASS_B, `set_m`=1, `inc_pc`=1. Next state EXEC.
  - JMP, or taken BZ/BN: `alu_op`=PASS_B, `set_pc`=1, `inc_pc`=0. Next state FETCH.
  - Untaken BZ/BN: `inc_pc`=1. Next state FETCH.
- EXEC (`addr_mux`=1, `inc_pc`=0):
  - LDA/ALU: `alu_op` per operation, `set_a`=1; flags latched as in OPER.
  - STA: `alu_op`=PASS_A, `we_out`=1.
  - Next state FETCH.
- HALT: all control outputs 0, `halted_out`=1. Stays in HALT until `rst_in`.
- Flags change only on the edges where `set_a` is asserted. STA, JMP and branches leave them unchanged.
- Invariant: `set_pc` and `inc_pc` are never both 1. At most one of `set_a`/`set_m`/`set_pc` is 1 in any cycle.

## Timing
- Reset: while `rst_in`=1, every output is forced to 0, including `we_out` and `halted_out`. On the clock edge, state <= FETCH, IR <= 0x00, Z <= 0, N <= 0. The datapath PC resets to 0x00.
- The first FETCH is the first cycle with `rst_in`=0, reading address 0x00.
- Reset asserted in any state, including mid-STA EXEC, suppresses `we_out` in that cycle and aborts the instruction; no partial register write occurs.
- Cycle counts:
  - NOP, undefined opcode: 1.
  - Immediate LDA/ALU, JMP, BZ, BN: 2.
  - Direct LDA/ALU, STA: 3.
- `we_out` is a single-cycle pulse in STA EXEC. Address and data are stable for that whole cycle.
- A branch tests the flags as latched before the branch's OPER cycle. A flag set by the immediately preceding instruction is visible.
- PC wrap-around: a fetch at 0xFF is followed by a fetch or operand read at 0x00. The controller needs no special handling.

## Test plan
- Program `11 05 31 03 28 80 F0` from reset:
  - `we_out`=1 for exactly one cycle, with `addr_out`=0x80 and `data_out`=0x08.
  - `halted_out` rises on the 9th cycle after reset release.
  - After that, outputs stay constant for 20 cycles.
- `11 05 41 05 91 20` (SUB to zero, then BZ): Z=1, the fetch after BZ reads 0x20. Repeat with `11 05 A1 20` (N=0): the next fetch is at 0x04.
- Direct `19 40` with mem[0x40]=0x9C:
  - `addr_out` sequence is 0x00, 0x01, 0x40, 0x02.
  - A=0x9C, N=1, Z=0.
  - 3 cycles.
- Opcode 0xB3 at 0x00: one cycle with no `set_*`/`we_out`; the next fetch is at 0x01. HLT at 0x05 leaves PC=0x06 and asserts `halted_out`.
- Assert `rst_in` during the STA EXEC cycle: `we_out` stays 0, and the first post-reset fetch is at 0x00 with Z=N=0.
- JMP 0xFF, then NOP at 0xFF: the next fetch is at 0x00 (wrap). Check `set_pc` & `inc_pc` never both high across all tests.
